// File: rtl/ahb_subordinate_mem_if.sv
// AHB-Lite bus bundle between a manager (plus its ready combiner) and the memory subordinate.
interface ahb_subordinate_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    HSELx;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [3:0]              HPROT;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic [DATA_WIDTH/8-1:0] HWSTRB;
    logic                    HREADY;
    logic                    HREADYOUT;
    logic                    HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;

    // HREADY is owned by the manager side (it stands in for the bus ready combiner)
    modport master (
        output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HWSTRB, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HWSTRB, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_subordinate_mem.sv
// AHB subordinate backed by a byte-addressed memory. Adds a fixed number of wait states to every
// OKAY data phase and answers out-of-window, misaligned or oversize transfers with the two-cycle
// ERROR response. Memory contents are not reset.
module ahb_subordinate_mem #(
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter int unsigned           MEM_ADDR_BITS = 12,
    parameter int unsigned           WAIT_STATES   = 0,
    parameter logic [ADDR_WIDTH-1:0] MIN_ADDR      = '0,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR      = ADDR_WIDTH'(12'hFFF)
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_subordinate_mem_if.slave bus
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
    localparam int unsigned WORD_BITS = MEM_ADDR_BITS - LANE_BITS;
    localparam int unsigned NUM_WORDS = 2 ** WORD_BITS;

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e                   state_q;
    logic                     pend_q;    // legal transfer currently in its data phase
    logic                     write_q;
    logic [2:0]               size_q;
    logic [MEM_ADDR_BITS-1:0] baddr_q;
    logic [3:0]               cnt_q;
    logic                     hreadyout_q;
    logic                     hresp_q;

    logic [DATA_WIDTH-1:0]    mem [NUM_WORDS];

    logic                     accept;
    logic                     illegal;
    logic [ADDR_WIDTH:0]      min_diff;
    logic [ADDR_WIDTH:0]      max_diff;
    int unsigned              lane_off;
    logic [NUM_LANES-1:0]     lane_mask;
    logic [NUM_LANES-1:0]     wr_lanes;
    logic [WORD_BITS-1:0]     word_idx;
    logic                     commit_wr;
    logic                     rd_valid;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     unused_bus;

    assign accept = bus.HSELx & bus.HREADY & bus.HTRANS[1];

    // The borrow out of each subtraction flags an address outside the legal window
    assign min_diff = {1'b0, bus.HADDR} - {1'b0, MIN_ADDR};
    assign max_diff = {1'b0, MAX_ADDR} - {1'b0, bus.HADDR};

    // Legality of the address phase currently on the bus
    always_comb begin
        illegal = min_diff[ADDR_WIDTH] | max_diff[ADDR_WIDTH];
        if (int'(bus.HSIZE) > int'(LANE_BITS)) begin
            illegal = 1'b1;
        end
        for (int i = 0; i < 7; i++) begin
            if (i < int'(bus.HSIZE) && bus.HADDR[i]) begin
                illegal = 1'b1;
            end
        end
    end

    // Single FSM: ERROR sequencing, wait-state countdown and sampling of the next address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            pend_q      <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= '0;
            baddr_q     <= '0;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else if (state_q == StErr1) begin
            state_q     <= StErr2;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b1;
        end else if (!hreadyout_q) begin
            // Still stretching an OKAY data phase
            if (cnt_q == '0) begin
                hreadyout_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end else begin
            // Any data phase in flight completes at this edge; next address phase is sampled
            state_q     <= StIdle;
            pend_q      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            if (accept) begin
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
                baddr_q <= bus.HADDR[MEM_ADDR_BITS-1:0];
                if (illegal) begin
                    state_q     <= StErr1;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= 1'b1;
                end else begin
                    pend_q <= 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_q     <= StWait;
                        hreadyout_q <= 1'b0;
                        cnt_q       <= 4'(WAIT_STATES - 1);
                    end
                end
            end
        end
    end

    assign lane_off = 32'(baddr_q) & (NUM_LANES - 1);
    assign word_idx = baddr_q[MEM_ADDR_BITS-1:LANE_BITS];

    // Byte lanes covered by the registered transfer (little-endian)
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (i >= lane_off && i < lane_off + (32'd1 << size_q)) begin
                lane_mask[i] = 1'b1;
            end
        end
    end

    assign commit_wr = pend_q & write_q & hreadyout_q;
    assign rd_valid  = pend_q & ~write_q & hreadyout_q;
    assign wr_lanes  = bus.HWSTRB & lane_mask;

    // Commit write bytes at the edge that closes an OKAY write data phase
    always_ff @(posedge HCLK) begin
        if (commit_wr) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (wr_lanes[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read data only on the completing cycle of an OKAY read; other lanes and phases read 0
    always_comb begin
        rdata = '0;
        if (rd_valid) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (lane_mask[i]) begin
                    rdata[8*i +: 8] = mem[word_idx][8*i +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

    // Burst type and protection carry no meaning for this memory
    assign unused_bus = ^{bus.HBURST, bus.HPROT};
endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Randomised bench for ahb_subordinate_mem: a pipelined driver issues transfers and queues them,
// a monitor retires each data phase against a byte-array reference memory.
module tb_ahb_subordinate_mem;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned WS = 3;
    localparam logic [31:0] MIN_A = 32'h0000_0000;
    localparam logic [31:0] MAX_A = 32'h0000_0FFF;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_subordinate_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_subordinate_mem #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_ADDR_BITS(12),
        .WAIT_STATES  (WS),
        .MIN_ADDR     (MIN_A),
        .MAX_ADDR     (MAX_A)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          chk;
        logic [31:0] exp;
    } op_t;

    op_t          ops[$];
    op_t          sb[$];
    byte unsigned model[4096];
    int           vectors = 0;
    int           miscompares = 0;

    bit           mon_open = 1'b0;
    int           mon_low = 0;
    bit           mon_resp = 1'b0;

    function automatic op_t mk(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                               logic [3:0] strb, logic [1:0] trans = 2'b10);
        op_t o;
        o.sel = 1'b1; o.trans = trans; o.burst = 3'b001; o.wr = wr; o.addr = addr;
        o.size = size; o.wdata = wdata; o.strb = strb; o.chk = 1'b0; o.exp = '0;
        return o;
    endfunction

    function automatic op_t mk_rd_chk(logic [31:0] addr, logic [31:0] exp);
        op_t o = mk(1'b0, addr, 3'd2, 32'h0, 4'h0);
        o.chk = 1'b1;
        o.exp = exp;
        return o;
    endfunction

    // Reference rules: window, natural alignment, size not wider than the bus
    function automatic bit ref_err(op_t o);
        longint unsigned nbytes = longint'(1) << o.size;
        return (longint'(o.addr) < longint'(MIN_A)) || (longint'(o.addr) > longint'(MAX_A)) ||
               (longint'(o.addr) % nbytes != 0) || (nbytes > DW / 8);
    endfunction

    function automatic logic [31:0] ref_read(op_t o);
        int unsigned a = o.addr % 4096;
        int unsigned base = a - a % 4;
        int unsigned off = a % 4;
        int unsigned n = 1 << o.size;
        logic [31:0] r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) r[8*i +: 8] = model[base + i];
        end
        return r;
    endfunction

    task automatic ref_write(op_t o);
        int unsigned a = o.addr % 4096;
        int unsigned base = a - a % 4;
        int unsigned off = a % 4;
        int unsigned n = 1 << o.size;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= off && i < off + n && o.strb[i]) model[base + i] = o.wdata[8*i +: 8];
        end
    endtask

    task automatic drive_addr(op_t o);
        bus.HSELx  = o.sel;
        bus.HTRANS = o.trans;
        bus.HBURST = o.burst;
        bus.HADDR  = o.addr;
        bus.HWRITE = o.wr;
        bus.HSIZE  = o.size;
        bus.HPROT  = 4'b0011;
    endtask

    task automatic drive_idle();
        bus.HSELx  = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HBURST = 3'b000;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HPROT  = 4'b0000;
    endtask

    // Pipelined manager: address phase of the next op overlaps the data phase of the previous one
    task automatic run_ops();
        op_t cur;
        op_t dp;
        bit  have_dp = 1'b0;
        bit  rdy;
        while (ops.size() > 0 || have_dp) begin
            if (ops.size() > 0) drive_addr(ops[0]);
            else drive_idle();
            if (have_dp) begin
                bus.HWDATA = dp.wdata;
                bus.HWSTRB = dp.strb;
            end else begin
                bus.HWDATA = '0;
                bus.HWSTRB = '0;
            end
            @(negedge HCLK);
            rdy = bus.HREADY;
            if (rdy) begin
                have_dp = 1'b0;
                if (ops.size() > 0) begin
                    cur = ops.pop_front();
                    if (cur.sel && cur.trans[1]) begin
                        sb.push_back(cur);
                        dp = cur;
                        have_dp = 1'b1;
                    end
                end
            end
            @(posedge HCLK);
            #1;
        end
        drive_idle();
    endtask

    task automatic retire(int low, bit saw_resp);
        op_t         o;
        bit          ok;
        bit          e_err;
        logic [31:0] e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_completion: got resp=%0b rdata=%h, want no data phase",
                     bus.HRESP, bus.HRDATA);
            return;
        end
        o = sb.pop_front();
        e_err = ref_err(o);
        e = '0;
        if (e_err) begin
            ok = (low == 1) && saw_resp && (bus.HRESP === 1'b1) && (bus.HRDATA === 32'h0);
        end else begin
            if (!o.wr) e = ref_read(o);
            ok = (low == WS) && !saw_resp && (bus.HRESP === 1'b0) &&
                 (o.wr || bus.HRDATA === e) && (!o.chk || bus.HRDATA === o.exp);
            if (o.wr) ref_write(o);
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL %s addr=%h size=%0d: got resp=%0b waits=%0d err_cycle=%0b rdata=%h, want err=%0b waits=%0d rdata=%h",
                     o.wr ? "write" : "read", o.addr, o.size, bus.HRESP, low, saw_resp,
                     bus.HRDATA, e_err, e_err ? 1 : WS, o.chk ? o.exp : e);
        end
    endtask

    // Monitor: retire each data phase when HREADYOUT rises; idle phases must be quiet OKAY
    initial begin
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                sb.delete();
                mon_open = 1'b0;
                mon_low = 0;
                mon_resp = 1'b0;
            end else begin
                if (mon_open) begin
                    if (!bus.HREADYOUT) begin
                        mon_low++;
                        if (bus.HRESP) mon_resp = 1'b1;
                    end else begin
                        retire(mon_low, mon_resp);
                    end
                end else begin
                    vectors++;
                    if (!(bus.HREADYOUT === 1'b1 && bus.HRESP === 1'b0 && bus.HRDATA === 32'h0)) begin
                        miscompares++;
                        $display("FAIL idle_phase: got ready=%0b resp=%0b rdata=%h, want 1 0 00000000",
                                 bus.HREADYOUT, bus.HRESP, bus.HRDATA);
                    end
                end
                if (bus.HREADY) begin
                    mon_open = bus.HSELx && bus.HTRANS[1];
                    mon_low = 0;
                    mon_resp = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t         o;
        int          r;
        logic [31:0] a;
        logic [2:0]  sz;

        drive_idle();
        bus.HWDATA = '0;
        bus.HWSTRB = '0;
        repeat (2) @(posedge HCLK);
        #1;
        vectors++;
        if (!(bus.HREADYOUT === 1'b1 && bus.HRESP === 1'b0 && bus.HRDATA === 32'h0)) begin
            miscompares++;
            $display("FAIL reset_state: got ready=%0b resp=%0b rdata=%h, want 1 0 00000000",
                     bus.HREADYOUT, bus.HRESP, bus.HRDATA);
        end
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Give every word the bench may read a known value
        for (int i = 0; i < 16; i++) ops.push_back(mk(1'b1, 32'(i * 4), 3'd2, $urandom(), 4'hF));
        ops.push_back(mk(1'b1, 32'hFFC, 3'd2, $urandom(), 4'hF));
        run_ops();

        // Directed: word write/read, byte lane merge, out-of-window, misaligned then ERR2 pickup
        ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 4'hF));
        ops.push_back(mk_rd_chk(32'h10, 32'hDEAD_BEEF));
        ops.push_back(mk(1'b1, 32'h13, 3'd0, 32'hA500_0000, 4'b1000));
        ops.push_back(mk_rd_chk(32'h10, 32'hA5AD_BEEF));
        ops.push_back(mk(1'b1, 32'h1000, 3'd2, 32'h1234_5678, 4'hF));
        ops.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0, 4'h0));
        ops.push_back(mk(1'b0, 32'h11, 3'd1, 32'h0, 4'h0));
        ops.push_back(mk_rd_chk(32'h10, 32'hA5AD_BEEF));
        // INCR4 word reads
        for (int i = 0; i < 4; i++) begin
            o = mk(1'b0, 32'h20 + 32'(i * 4), 3'd2, 32'h0, 4'h0, (i == 0) ? 2'b10 : 2'b11);
            o.burst = 3'b011;
            ops.push_back(o);
        end
        run_ops();

        // Random traffic: mostly in the initialised window, some outside, some idle/busy/unselected
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) a = 32'($urandom_range(0, 63));
            else if (r < 90) a = 32'h1000 + 32'($urandom_range(0, 255));
            else a = 32'hFFC + 32'($urandom_range(0, 3));
            sz = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            o = mk(1'($urandom_range(0, 1)), a, sz, $urandom(), 4'($urandom_range(0, 15)),
                   2'($urandom_range(2, 3)));
            if ($urandom_range(0, 9) == 0) o.trans = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 8) o.sel = 1'b0;
            ops.push_back(o);
        end
        run_ops();

        // Reset during the wait states of a write: abandon it, memory keeps the old word
        o = mk(1'b1, 32'h20, 3'd2, 32'hCAFE_F00D, 4'hF);
        drive_addr(o);
        @(negedge HCLK);
        sb.push_back(o);
        @(posedge HCLK);
        #1;
        drive_idle();
        bus.HWDATA = o.wdata;
        bus.HWSTRB = 4'hF;
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        vectors++;
        if (!(bus.HREADYOUT === 1'b1 && bus.HRESP === 1'b0)) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got ready=%0b resp=%0b, want 1 0",
                     bus.HREADYOUT, bus.HRESP);
        end
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        ops.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0, 4'h0));
        run_ops();
        repeat (2) @(posedge HCLK);
        #1;

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d outstanding transfers, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
